// File: rtl/uart_tx_sched.sv
// uart_tx_sched - UART transmit-path controller.
//
// Two cooperating blocks:
//   * Round-robin arbiter: picks one of NUM_REQ byte producers per cycle and
//     drives the single TX FIFO write port (combinational grant, registered
//     round-robin pointer and grant index).
//   * Sequencer FSM (IDLE -> POP -> LOAD -> SEND -> WAIT): pops one byte from
//     the FIFO, latches it for the transmitter, fires a one-cycle start pulse
//     and waits for the frame-complete pulse.
//
// Optional feature (macro UART_TX_SCHED_LOCK_EN): adds req_last so a producer
// can hold the grant across a multi-byte message. Undefined by default.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester byte valid
//   req_data      requester i byte on [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last      (lock build only) last byte of a locked message
//   req_ready     per-requester accept (combinational)
//   fifo_wr_en    FIFO write strobe (combinational)
//   fifo_wr_data  FIFO write byte (combinational)
//   fifo_full     FIFO full
//   fifo_rd_en    FIFO read strobe (registered)
//   fifo_rd_data  FIFO read byte, valid the cycle after fifo_rd_en
//   fifo_empty    FIFO empty
//   uart_start    one-cycle transmitter start pulse (registered)
//   uart_data     byte to transmit, held from SEND until done (registered)
//   uart_busy     transmitter busy
//   uart_done     one-cycle frame-complete pulse
//   grant_id      index of the last accepted requester (registered)
//   tx_count      bytes handed to the transmitter, wrapping (registered)
//   idle          sequencer in IDLE and FIFO empty
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
    input  logic                          fifo_empty,
    output logic                          uart_start,
    output logic [DATA_WIDTH-1:0]         uart_data,
    input  logic                          uart_busy,
    input  logic                          uart_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [CNT_WIDTH-1:0]          tx_count,
    output logic                          idle
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]      rr_ptr_r;
    logic [PTR_W-1:0]      grant_id_r;
    logic [PTR_W-1:0]      rr_grant_s;
    logic                  rr_found_s;
    logic [PTR_W-1:0]      grant_s;
    logic                  found_s;
    logic [PTR_W-1:0]      next_ptr_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic                  fifo_wr_en_s;
    logic [DATA_WIDTH-1:0] req_bytes_s [NUM_REQ];
`ifdef UART_TX_SCHED_LOCK_EN
    logic                  lock_r;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes_s[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin : rr_search
        int idx_v;
        idx_v      = 0;
        rr_grant_s = rr_ptr_r;
        rr_found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = ((int'(rr_ptr_r) + i) >= NUM_REQ) ? (int'(rr_ptr_r) + i - NUM_REQ)
                                                      : (int'(rr_ptr_r) + i);
            if (!rr_found_s && req_valid[PTR_W'(idx_v)]) begin
                rr_found_s = 1'b1;
                rr_grant_s = PTR_W'(idx_v);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Final grant: a held lock overrides the round-robin choice.
    always_comb begin
        grant_s = rr_grant_s;
        found_s = rr_found_s;
`ifdef UART_TX_SCHED_LOCK_EN
        if (lock_r) begin
            grant_s = grant_id_r;
            found_s = req_valid[grant_id_r];
        end else begin
            grant_s = rr_grant_s;
            found_s = rr_found_s;
        end
`endif
    end

    assign next_ptr_s   = (grant_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (grant_s + PTR_W'(1));
    assign fifo_wr_en_s = found_s & ~fifo_full;

    // Only the granted requester sees ready, and only when the FIFO has room.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (found_s) begin
            req_ready_s[grant_s] = ~fifo_full;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Pointer, grant index and lock update on every accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= {PTR_W{1'b0}};
            grant_id_r <= {PTR_W{1'b0}};
`ifdef UART_TX_SCHED_LOCK_EN
            lock_r     <= 1'b0;
`endif
        end else if (fifo_wr_en_s) begin
            grant_id_r <= grant_s;
`ifdef UART_TX_SCHED_LOCK_EN
            // A non-last byte pins the grant; the pointer only moves on release.
            if (req_last[grant_s]) begin
                lock_r   <= 1'b0;
                rr_ptr_r <= next_ptr_s;
            end else begin
                lock_r   <= 1'b1;
            end
`else
            rr_ptr_r   <= next_ptr_s;
`endif
        end
    end

    assign req_ready    = req_ready_s;
    assign fifo_wr_en   = fifo_wr_en_s;
    assign fifo_wr_data = req_bytes_s[grant_s];
    assign grant_id     = grant_id_r;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t                state_r;
    state_t                state_next_s;
    logic                  fifo_rd_en_r;
    logic                  uart_start_r;
    logic [DATA_WIDTH-1:0] uart_data_r;
    logic [CNT_WIDTH-1:0]  tx_count_r;

    // Next-state logic; uart_done is only looked at in WAIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty && !uart_busy) begin
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_POP:  state_next_s = ST_LOAD;
            ST_LOAD: state_next_s = ST_SEND;
            ST_SEND: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (uart_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; strobes are decoded from the next state so they are
    // flop outputs yet still line up with the POP and SEND cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fifo_rd_en_r <= 1'b0;
            uart_start_r <= 1'b0;
            uart_data_r  <= {DATA_WIDTH{1'b0}};
            tx_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            fifo_rd_en_r <= (state_next_s == ST_POP);
            uart_start_r <= (state_next_s == ST_SEND);
            if (state_r == ST_LOAD) begin
                uart_data_r <= fifo_rd_data;
            end
            if (state_r == ST_SEND) begin
                tx_count_r <= tx_count_r + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_rd_en = fifo_rd_en_r;
    assign uart_start = uart_start_r;
    assign uart_data  = uart_data_r;
    assign tx_count   = tx_count_r;
    assign idle       = (state_r == ST_IDLE) & fifo_empty;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NUM_REQ=4, DATA_WIDTH=8, CNT_WIDTH=16).
// Arbiter behaviour is checked from a vector table; the sequencer, reset and
// optional lock behaviour from hand-written sequences. A small FIFO model
// inside the bench answers the DUT's write/read strobes.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic        uart_done;
    logic [1:0]  grant_id;
    logic [15:0] tx_count;
    logic        idle;
`ifdef UART_TX_SCHED_LOCK_EN
    logic [3:0]  req_last;
`endif

    uart_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
        .req_last     (req_last),
`endif
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .uart_start   (uart_start),
        .uart_data    (uart_data),
        .uart_busy    (uart_busy),
        .uart_done    (uart_done),
        .grant_id     (grant_id),
        .tx_count     (tx_count),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [7:0] q[$];

    typedef struct packed {
        logic [3:0] valid;
        logic       full;
        logic [3:0] exp_ready;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample strobes before the edge, then update the FIFO model.
    task automatic tick();
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        #2;
        wr = fifo_wr_en;
        wd = fifo_wr_data;
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd) begin
            check("rd_while_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) fifo_rd_data = q.pop_front();
        end
        if (wr) q.push_back(wd);
        fifo_empty = (q.size() == 0);
        if (uart_start) start_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        logic [7:0] drain_bytes [3];

        rst = 1'b1; req_valid = 4'b0000; req_data = 32'hD3C2B1A0;
        fifo_full = 1'b0; fifo_rd_data = 8'h00; fifo_empty = 1'b1;
        uart_busy = 1'b1; uart_done = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
        req_last = 4'b1111;
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        // reset state
        check("rst_rd_en",    32'(fifo_rd_en), 32'd0);
        check("rst_start",    32'(uart_start), 32'd0);
        check("rst_data",     32'(uart_data),  32'd0);
        check("rst_tx_count", 32'(tx_count),   32'd0);
        check("rst_grant",    32'(grant_id),   32'd0);
        check("rst_idle",     32'(idle),       32'd1);
        check("rst_ready",    32'(req_ready),  32'd0);
        check("rst_wr_en",    32'(fifo_wr_en), 32'd0);

        // arbiter table (busy=1 keeps the sequencer parked)
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2};
        vecs[8]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[9]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[10] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[11] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[12] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2};
        for (int v = 0; v < 13; v++) begin
            req_valid = vecs[v].valid;
            fifo_full = vecs[v].full;
            #1;
            check($sformatf("arb_ready[%0d]", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            check($sformatf("arb_wr_en[%0d]", v), 32'(fifo_wr_en), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr)
                check($sformatf("arb_wr_data[%0d]", v), 32'(fifo_wr_data), 32'(vecs[v].exp_data));
            tick();
            check($sformatf("arb_grant[%0d]", v), 32'(grant_id), 32'(vecs[v].exp_grant));
        end

        // backpressure: pointer sits at 3, full for 10 cycles
        req_valid = 4'b0110; fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_wr_en", 32'(fifo_wr_en), 32'd0);
            tick();
            check("bp_grant", 32'(grant_id), 32'd2);
        end
        fifo_full = 1'b0;
        #1;
        check("bp_rel_ready1", 32'(req_ready), 32'b0010);
        check("bp_rel_data1", 32'(fifo_wr_data), 32'hB1);
        tick();
        check("bp_rel_grant1", 32'(grant_id), 32'd1);
        check("bp_rel_ready2", 32'(req_ready), 32'b0100);
        check("bp_rel_data2", 32'(fifo_wr_data), 32'hC2);
        tick();
        check("bp_rel_grant2", 32'(grant_id), 32'd2);
        req_valid = 4'b0000;

        // single byte end to end
        q.delete(); fifo_empty = 1'b1;
        req_data = 32'hD3C2B1A5; uart_busy = 1'b0; req_valid = 4'b0001;
        #1;
        check("sb_wr_en", 32'(fifo_wr_en), 32'd1);
        check("sb_wr_data", 32'(fifo_wr_data), 32'hA5);
        tick();
        req_valid = 4'b0000;
        check("sb_rd_t0", 32'(fifo_rd_en), 32'd0);
        tick();
        check("sb_rd_t1", 32'(fifo_rd_en), 32'd1);
        check("sb_start_t1", 32'(uart_start), 32'd0);
        tick();
        check("sb_rd_t2", 32'(fifo_rd_en), 32'd0);
        tick();
        check("sb_start_t3", 32'(uart_start), 32'd1);
        check("sb_data_t3", 32'(uart_data), 32'hA5);
        check("sb_cnt_t3", 32'(tx_count), 32'd0);
        uart_busy = 1'b1;
        tick();
        check("sb_start_t4", 32'(uart_start), 32'd0);
        check("sb_cnt_t4", 32'(tx_count), 32'd1);
        tick(); tick(); tick();
        check("sb_data_hold", 32'(uart_data), 32'hA5);
        check("sb_not_idle", 32'(idle), 32'd0);
        uart_done = 1'b1; uart_busy = 1'b0;
        tick();
        uart_done = 1'b0;
        check("sb_idle", 32'(idle), 32'd1);

        // reset in the middle of a frame
        q.push_back(8'h5A); fifo_empty = 1'b0;
        n = 0;
        while (!uart_start && n < 10) begin tick(); n++; end
        check("mr_start_seen", 32'(uart_start), 32'd1);
        uart_busy = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mr_start", 32'(uart_start), 32'd0);
        check("mr_data", 32'(uart_data), 32'd0);
        check("mr_tx_count", 32'(tx_count), 32'd0);
        check("mr_grant", 32'(grant_id), 32'd0);
        check("mr_idle", 32'(idle), 32'd1);
        s0 = start_cnt;
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0; uart_busy = 1'b0;
        repeat (5) tick();
        check("mr_no_start", 32'(start_cnt), 32'(s0));
        check("mr_still_idle", 32'(idle), 32'd1);
        req_valid = 4'b1111;
        #1;
        check("mr_ptr_reset", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;

        // back-to-back drain of three bytes
        drain_bytes[0] = 8'h11; drain_bytes[1] = 8'h22; drain_bytes[2] = 8'h33;
        for (int k = 0; k < 3; k++) q.push_back(drain_bytes[k]);
        fifo_empty = 1'b0;
        s0 = start_cnt;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!uart_start && n < 10) begin tick(); n++; end
            check($sformatf("dr_start[%0d]", k), 32'(uart_start), 32'd1);
            check($sformatf("dr_data[%0d]", k), 32'(uart_data), 32'(drain_bytes[k]));
            uart_busy = 1'b1;
            repeat (19) tick();
            uart_done = 1'b1; uart_busy = 1'b0;
            tick();
            uart_done = 1'b0;
            check($sformatf("dr_gap[%0d]", k), 32'(fifo_rd_en), 32'd0);
            tick();
            check($sformatf("dr_pop[%0d]", k), 32'(fifo_rd_en), (k < 2) ? 32'd1 : 32'd0);
        end
        check("dr_start_count", 32'(start_cnt - s0), 32'd3);
        check("dr_tx_count", 32'(tx_count), 32'd3);
        check("dr_idle", 32'(idle), 32'd1);

`ifdef UART_TX_SCHED_LOCK_EN
        // lock: requester 2 sends three bytes while requester 0 waits
        uart_busy = 1'b1;
        req_valid = 4'b0010; req_last = 4'b0010;
        tick();
        check("lk_pre_grant", 32'(grant_id), 32'd1);
        req_valid = 4'b0101; req_last = 4'b0000;
        #1;
        check("lk_w1_ready", 32'(req_ready), 32'b0100);
        tick();
        check("lk_w1_grant", 32'(grant_id), 32'd2);
        check("lk_w2_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        #1;
        check("lk_gap_ready", 32'(req_ready), 32'b0000);
        check("lk_gap_wr_en", 32'(fifo_wr_en), 32'd0);
        tick();
        req_valid = 4'b0101; req_last = 4'b0100;
        #1;
        check("lk_w3_ready", 32'(req_ready), 32'b0100);
        tick();
        check("lk_w3_grant", 32'(grant_id), 32'd2);
        check("lk_rel_ready", 32'(req_ready), 32'b0001);
        tick();
        check("lk_rel_grant", 32'(grant_id), 32'd0);
        req_valid = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
